// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores to a variable-latency data memory over req/ack and registers the WB bundle.
// Latency 1 cycle to wb_*; stall is raised combinationally while an access is outstanding, cleared in the ack cycle.
module mem_access_stage #(
    parameter int DSIZE   = 32,
    parameter int ASIZE   = 5,
    parameter int ISIZE   = 32,
    parameter int MEM_AW  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen_in,
    input  logic [DSIZE-1:0]  alu_in,
    input  logic [ASIZE-1:0]  waddr_in,
    input  logic [DSIZE-1:0]  rdata2_in,
    input  logic              jal_in,
    input  logic              memRead_in,
    input  logic              memWrite_in,
    input  logic              memtoReg_in,
    input  logic [ISIZE-1:0]  pc_in,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [MEM_AW-1:0] dmem_addr,
    output logic [DSIZE-1:0]  dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DSIZE-1:0]  dmem_rdata,
    output logic              wb_wen,
    output logic [ASIZE-1:0]  wb_waddr,
    output logic [DSIZE-1:0]  wb_wdata,
    output logic              mem_err
);

    // DROP spends one cycle with req low so the held, timed-out op is retired without reissue.
    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

    state_t             state, state_nxt;
    logic [7:0]         cnt, cnt_nxt;
    logic               mem_op;
    logic               pass, done, capture, abort;

    logic [DSIZE-1:0]   l_alu, l_wdata;
    logic [ASIZE-1:0]   l_waddr;
    logic               l_we, l_wen, l_m2r;

    logic               c_we, c_wen, c_m2r;
    logic [ASIZE-1:0]   c_waddr;
    logic [DSIZE-1:0]   c_alu;

    assign mem_op = memRead_in | memWrite_in;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stall      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        pass       = 1'b0;
        done       = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    dmem_req   = 1'b1;
                    dmem_we    = memWrite_in;
                    dmem_addr  = alu_in[MEM_AW-1:0];
                    dmem_wdata = rdata2_in;
                    if (dmem_ack) begin
                        done = 1'b1;
                    end else begin
                        stall = 1'b1;
                        if (TIMEOUT <= 1) begin
                            abort     = 1'b1;
                            state_nxt = DROP;
                        end else begin
                            capture   = 1'b1;
                            state_nxt = BUSY;
                            cnt_nxt   = 8'd1;
                        end
                    end
                end else begin
                    pass = 1'b1;
                end
            end
            BUSY: begin
                dmem_req   = 1'b1;
                dmem_we    = l_we;
                dmem_addr  = l_alu[MEM_AW-1:0];
                dmem_wdata = l_wdata;
                if (dmem_ack) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    stall = 1'b1;
                    // cnt already includes the issue cycle, so this is the TIMEOUT-th stalled cycle
                    if (cnt >= 8'(TIMEOUT - 1)) begin
                        abort     = 1'b1;
                        state_nxt = DROP;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            DROP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!rst) begin
            stall      = 1'b0;
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            dmem_addr  = '0;
            dmem_wdata = '0;
        end
    end

    always_comb begin
        c_we    = memWrite_in;
        c_wen   = wen_in;
        c_waddr = waddr_in;
        c_m2r   = memtoReg_in;
        c_alu   = alu_in;
        if (state == BUSY) begin
            c_we    = l_we;
            c_wen   = l_wen;
            c_waddr = l_waddr;
            c_m2r   = l_m2r;
            c_alu   = l_alu;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            l_alu   <= '0;
            l_wdata <= '0;
            l_waddr <= '0;
            l_we    <= 1'b0;
            l_wen   <= 1'b0;
            l_m2r   <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                l_alu   <= alu_in;
                l_wdata <= rdata2_in;
                l_waddr <= waddr_in;
                l_we    <= memWrite_in;
                l_wen   <= wen_in;
                l_m2r   <= memtoReg_in;
            end
            if (abort) begin
                mem_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_wen   <= 1'b0;
            wb_waddr <= '0;
            wb_wdata <= '0;
        end else if (pass) begin
            wb_wen   <= wen_in & (waddr_in != '0);
            wb_waddr <= waddr_in;
            wb_wdata <= jal_in ? DSIZE'(pc_in) : alu_in;
        end else if (done && !c_we) begin
            wb_wen   <= c_wen & (c_waddr != '0);
            wb_waddr <= c_waddr;
            wb_wdata <= c_m2r ? dmem_rdata : c_alu;
        end else begin
            // stall bubble, completed store, or abort: nothing to write back
            wb_wen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus random instruction stream against a per-instruction model.
module tb_mem_access_stage;

    localparam int DSIZE = 32;
    localparam int ASIZE = 5;
    localparam int ISIZE = 32;
    localparam int MEM_AW = 10;
    localparam int T = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              wen_in, jal_in, memRead_in, memWrite_in, memtoReg_in;
    logic [DSIZE-1:0]  alu_in, rdata2_in, dmem_rdata;
    logic [ASIZE-1:0]  waddr_in;
    logic [ISIZE-1:0]  pc_in;
    logic              dmem_ack;
    logic              stall, dmem_req, dmem_we, wb_wen, mem_err;
    logic [MEM_AW-1:0] dmem_addr;
    logic [DSIZE-1:0]  dmem_wdata, wb_wdata;
    logic [ASIZE-1:0]  wb_waddr;

    mem_access_stage #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .ISIZE(ISIZE), .MEM_AW(MEM_AW), .TIMEOUT(T)
    ) dut (
        .clk(clk), .rst(rst), .wen_in(wen_in), .alu_in(alu_in), .waddr_in(waddr_in),
        .rdata2_in(rdata2_in), .jal_in(jal_in), .memRead_in(memRead_in),
        .memWrite_in(memWrite_in), .memtoReg_in(memtoReg_in), .pc_in(pc_in),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // model expectations for the current cycle
    logic              chk_en = 1'b0;
    logic              exp_stall, exp_req, exp_we, exp_wb_wen, exp_err;
    logic [MEM_AW-1:0] exp_addr;
    logic [DSIZE-1:0]  exp_wdata, exp_wb_wdata;
    logic [ASIZE-1:0]  exp_wb_waddr;

    // observations gathered by the compare process
    int                stall_cnt = 0;
    int                req_cnt = 0;
    logic [MEM_AW-1:0] last_addr = '0;
    logic [DSIZE-1:0]  last_wdata = '0;
    logic              last_we = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", {31'd0, stall}, {31'd0, exp_stall});
            chk("dmem_req", {31'd0, dmem_req}, {31'd0, exp_req});
            if (exp_req) begin
                chk("dmem_we", {31'd0, dmem_we}, {31'd0, exp_we});
                chk("dmem_addr", 32'(dmem_addr), 32'(exp_addr));
                chk("dmem_wdata", dmem_wdata, exp_wdata);
            end
            chk("wb_wen", {31'd0, wb_wen}, {31'd0, exp_wb_wen});
            chk("wb_waddr", 32'(wb_waddr), 32'(exp_wb_waddr));
            chk("wb_wdata", wb_wdata, exp_wb_wdata);
            chk("mem_err", {31'd0, mem_err}, {31'd0, exp_err});
            if (stall) stall_cnt++;
            if (dmem_req) begin
                req_cnt++;
                last_addr = dmem_addr;
                last_wdata = dmem_wdata;
                last_we = dmem_we;
            end
        end
    end

    // One instruction from EXE/MEM; lat = cycles until ack (>= T means never in time). Called at posedge+1.
    task automatic run_instr(input logic wen, input logic [4:0] wa, input logic [31:0] alu,
                             input logic [31:0] r2, input logic jal, input logic rd, input logic wr,
                             input logic m2r, input logic [31:0] pc, input int lat,
                             input logic [31:0] rdv);
        logic fin;
        wen_in = wen; waddr_in = wa; alu_in = alu; rdata2_in = r2; jal_in = jal;
        memRead_in = rd; memWrite_in = wr; memtoReg_in = m2r; pc_in = pc;
        if (!(rd | wr)) begin
            dmem_ack = ($urandom_range(0, 3) == 0);
            dmem_rdata = $urandom;
            exp_stall = 1'b0; exp_req = 1'b0;
            @(posedge clk);
            exp_wb_wen = wen && (wa != 0);
            exp_wb_waddr = wa;
            exp_wb_wdata = jal ? pc : alu;
            #1;
        end else begin
            fin = 1'b0;
            for (int k = 0; k < T && !fin; k++) begin
                fin = (k == lat);
                dmem_ack = fin;
                dmem_rdata = fin ? rdv : $urandom;
                exp_stall = !fin; exp_req = 1'b1; exp_we = wr;
                exp_addr = alu[MEM_AW-1:0]; exp_wdata = r2;
                @(posedge clk);
                if (fin && !wr) begin
                    exp_wb_wen = wen && (wa != 0);
                    exp_wb_waddr = wa;
                    exp_wb_wdata = m2r ? rdv : alu;
                end else begin
                    exp_wb_wen = 1'b0;
                end
                #1;
            end
            if (!fin) begin
                // timed out: one idle cycle with req low, late ack must be ignored
                exp_err = 1'b1;
                dmem_ack = $urandom_range(0, 1);
                dmem_rdata = $urandom;
                exp_stall = 1'b0; exp_req = 1'b0;
                @(posedge clk);
                exp_wb_wen = 1'b0;
                #1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0;
        rst = 1'b0;
        wen_in = 0; jal_in = 0; memRead_in = 0; memWrite_in = 0; memtoReg_in = 0;
        alu_in = '0; rdata2_in = '0; waddr_in = '0; pc_in = '0; dmem_ack = 0; dmem_rdata = '0;
        exp_stall = 0; exp_req = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0;
        exp_wb_wen = 0; exp_wb_waddr = '0; exp_wb_wdata = '0; exp_err = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_req", {31'd0, dmem_req}, 32'd0);
        chk("reset_wb_wen", {31'd0, wb_wen}, 32'd0);
        chk("reset_wb_wdata", wb_wdata, 32'd0);
        chk("reset_mem_err", {31'd0, mem_err}, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;

        // ALU pass-through
        run_instr(1, 5'd3, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_wb_wen", {31'd0, wb_wen}, 32'd1);
        chk("t1_wb_waddr", 32'(wb_waddr), 32'd3);
        chk("t1_wb_wdata", wb_wdata, 32'h1234);

        // zero-wait load
        s0 = stall_cnt;
        run_instr(1, 5'd5, 32'h40, 0, 0, 1, 0, 1, 0, 0, 32'hDEAD);
        chk("t2_addr", 32'(last_addr), 32'h40);
        chk("t2_stalls", stall_cnt - s0, 0);
        chk("t2_wb_wen", {31'd0, wb_wen}, 32'd1);
        chk("t2_wb_wdata", wb_wdata, 32'hDEAD);

        // 3-wait store
        s0 = stall_cnt; r0 = req_cnt;
        run_instr(1, 5'd7, 32'h10, 32'hBEEF, 0, 0, 1, 0, 0, 3, 0);
        chk("t3_stalls", stall_cnt - s0, 3);
        chk("t3_reqs", req_cnt - r0, 4);
        chk("t3_wdata", last_wdata, 32'hBEEF);
        chk("t3_wb_wen", {31'd0, wb_wen}, 32'd0);
        chk("t3_wb_hold", wb_wdata, 32'hDEAD);
        chk("t3_mem_err", {31'd0, mem_err}, 32'd0);

        // last cycle before the timeout still completes
        s0 = stall_cnt;
        run_instr(1, 5'd6, 32'h22, 0, 0, 1, 0, 1, 0, T - 1, 32'h5A5A);
        chk("tb_stalls", stall_cnt - s0, T - 1);
        chk("tb_wb_wdata", wb_wdata, 32'h5A5A);
        chk("tb_mem_err", {31'd0, mem_err}, 32'd0);

        // timeout
        s0 = stall_cnt; r0 = req_cnt;
        run_instr(1, 5'd8, 32'h44, 0, 0, 1, 0, 1, 0, 1000, 0);
        chk("t4_stalls", stall_cnt - s0, T);
        chk("t4_reqs", req_cnt - r0, T);
        chk("t4_mem_err", {31'd0, mem_err}, 32'd1);
        chk("t4_wb_wen", {31'd0, wb_wen}, 32'd0);

        // async reset while BUSY
        chk_en = 1'b0;
        wen_in = 1; waddr_in = 5'd4; alu_in = 32'h80; memRead_in = 1; memWrite_in = 0;
        memtoReg_in = 1; jal_in = 0; dmem_ack = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t5_req", {31'd0, dmem_req}, 32'd0);
        chk("t5_stall", {31'd0, stall}, 32'd0);
        chk("t5_wb_waddr", 32'(wb_waddr), 32'd0);
        chk("t5_wb_wdata", wb_wdata, 32'd0);
        chk("t5_mem_err", {31'd0, mem_err}, 32'd0);
        @(negedge clk);
        wen_in = 0; waddr_in = '0; alu_in = '0; memRead_in = 0; memtoReg_in = 0;
        exp_stall = 0; exp_req = 0; exp_wb_wen = 0; exp_wb_waddr = '0; exp_wb_wdata = '0; exp_err = 0;
        #1 rst = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;

        // jal, load to r0, read+write together
        run_instr(1, 5'd31, 32'h999, 0, 1, 0, 0, 0, 32'h21, 0, 0);
        chk("t6_jal_wdata", wb_wdata, 32'h21);
        chk("t6_jal_wen", {31'd0, wb_wen}, 32'd1);
        run_instr(1, 5'd0, 32'h30, 0, 0, 1, 0, 1, 0, 1, 32'h77);
        chk("t6_r0_wen", {31'd0, wb_wen}, 32'd0);
        run_instr(1, 5'd9, 32'h31, 32'hCAFE, 0, 1, 1, 1, 0, 0, 32'h88);
        chk("t6_rw_we", {31'd0, last_we}, 32'd1);
        chk("t6_rw_wen", {31'd0, wb_wen}, 32'd0);

        // random stream
        for (int n = 0; n < 300; n++) begin
            int kind, lsel, lat;
            logic rd, wr, jl;
            logic [4:0] wa;
            kind = $urandom_range(0, 19);
            rd = 0; wr = 0; jl = 0;
            if (kind < 7) ;
            else if (kind < 12) rd = 1;
            else if (kind < 17) wr = 1;
            else if (kind < 18) begin rd = 1; wr = 1; end
            else jl = 1;
            wa = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            lsel = $urandom_range(0, 9);
            if (lsel < 6) lat = $urandom_range(0, 3);
            else if (lsel < 8) lat = $urandom_range(4, T - 1);
            else lat = $urandom_range(T, T + 25);
            run_instr(1'($urandom_range(0, 1)), wa, $urandom, $urandom, jl, rd, wr,
                      1'($urandom_range(0, 1)), $urandom, lat, $urandom);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
